fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage of the RISC-V pipeline: it produces the `instruction`/`pc` pair consumed by decode. It issues word fetches to instruction memory over a request/grant + in-order response interface and buffers up to two returned words. It inserts all-zero bubbles while decode holds a branch pending, and redirects to the branch target when EX resolves the branch as taken.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- NOP_INSN, 32'h0000_0000, bubble word; decode treats opcode 7'b0000000 as a no-op
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address, word aligned
- imem_gnt  in  1  request accepted this cycle when high together with imem_req
- imem_rvalid  in  1  response word valid; responses return in request order
- imem_rdata  in  32  response word
- pc_nop_control  in  1  from decode: the current instruction is a branch; freeze fetch
- branch_resolve  in  1  from EX: branch outcome valid, one-cycle pulse
- branch_taken  in  1  qualified by branch_resolve
- branch_target  in  32  qualified by branch_resolve
- instruction  out  32  registered instruction to decode
- id_pc  out  32  registered PC of `instruction`, drives decode `input_pc`

## Operation
- State: fetch_pc; 2-entry FIFO of {pc, insn}; outstanding count (0–2); drop_cnt (0–2); saved target; FSM state.
- FSM states:
  - RUN: normal fetch and issue.
  - BR_WAIT: branch pending in decode.
  - REDIRECT: taken branch; a stale request has not yet been granted.
- Issue rule: imem_req = 1 when a request is already pending ungranted, or when state = RUN and outstanding + FIFO occupancy < 2.
- imem_addr = fetch_pc.
- Once raised, imem_req and imem_addr stay stable until imem_gnt, in every state.
- Grant: outstanding +1 and fetch_pc += 4 (mod 2^32; 32'hFFFF_FFFC wraps to 0). In REDIRECT the grant instead loads fetch_pc with the saved target.
- Response: outstanding −1. If drop_cnt ≠ 0, the word is discarded and drop_cnt −1; otherwise push {pc of that request, imem_rdata}.
- The credit rule guarantees the FIFO never overflows. An rvalid while outstanding = 0 is a protocol error and is ignored.
- RUN output:
  - If the FIFO is non-empty, pop the head into instruction/id_pc.
  - If the FIFO is empty, instruction ← NOP_INSN and id_pc holds.
- pc_nop_control = 1 in RUN: the next edge enters BR_WAIT and loads NOP_INSN. No pop happens that edge, and no new requests are issued afterwards.
- BR_WAIT: instruction ← NOP_INSN every cycle. Responses keep filling the FIFO.
- branch_resolve in BR_WAIT, not taken: go to RUN. The FIFO contents are kept and popping resumes on the next edge.
- branch_resolve in BR_WAIT, taken:
  - Flush the FIFO.
  - drop_cnt ← outstanding after this cycle's grant/response.
  - branch_target[1:0] is forced to 00.
  - If no request is pending ungranted: fetch_pc ← target and go to RUN.
  - If a request is pending ungranted: save the target and go to REDIRECT.
- REDIRECT: on imem_gnt, drop_cnt +1, fetch_pc ← saved target, go to RUN.
- branch_resolve outside BR_WAIT is ignored. pc_nop_control outside RUN is ignored.

## Timing
- Reset values:
  - instruction = NOP_INSN, id_pc = RESET_PC.
  - fetch_pc = RESET_PC, state = RUN.
  - FIFO empty, outstanding = 0, drop_cnt = 0.
  - imem_req forced 0 while rst is high.
- First request: imem_req = 1 in the first cycle after rst deasserts.
- Latency: imem_rvalid at edge n → word visible on instruction after edge n+1 (when the FIFO was empty).
- Throughput: one instruction per cycle with zero-wait memory (gnt and rvalid the next cycle).
- Simultaneous push and pop in the same cycle are both performed.
- Simultaneous pc_nop_control and rvalid: the word is pushed and not popped.
- A taken resolve in the same cycle as a response is handled as described above; that response does not count toward drop_cnt.
- Reset mid-operation clears all state immediately. imem is reset by the same rst.

## Structure
- Package fetch_pkg holds:
  - NOP_INSN and RESET_PC defaults.
  - The FSM enum typedef {RUN, BR_WAIT, REDIRECT}.
  - The FIFO entry struct {pc[31:0], insn[31:0]}.
- Sub-module fetch_buffer: 2-entry synchronous FIFO with push, pop, flush, count, head outputs, and async active-high reset.

## Test plan
- Reset release, memory with gnt always 1 and rvalid one cycle after grant returning addr^32'hA5A5_0000 → instruction sequence 0xA5A50000, 0xA5A50004, … with id_pc 0, 4, 8, … and no bubbles after the first fill.
- gnt held low for 3 cycles → imem_addr stable at 0x8 and imem_req stays 1; instruction shows NOP_INSN once the FIFO drains.
- pc_nop_control on insn at pc 0x10, not-taken resolve 2 cycles later → NOP_INSN for 2 cycles, then pc 0x14 with no word lost or duplicated.
- pc_nop_control at pc 0x10, two responses still in flight, taken resolve to 0x103 → both stale words dropped; the next instruction has id_pc 0x100.
- Taken resolve while a request is pending ungranted at 0x18, gnt 2 cycles later → REDIRECT; the stale response is dropped, then imem_addr = target.
- Assert rst mid-stream with FIFO full → instruction = NOP_INSN, id_pc = RESET_PC, imem_req = 0 immediately; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
// Imported by fetch_buffer and fetch_unit.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INSN_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    RUN,
    BR_WAIT,
    REDIRECT
  } fstate_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } fentry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of {pc, insn} pairs between imem and decode.
// Flush wins over a same-cycle push.
module fetch_buffer
  import fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic       flush_i,
  input  fentry_t    din_i,
  output fentry_t    head_o,
  output logic [1:0] count_o
);

  fentry_t    mem_q [2];
  logic       rd_q;
  logic       wr_q;
  logic [1:0] cnt_q;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else if (flush_i) begin
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (push_i) wr_q <= ~wr_q;
      if (pop_i) rd_q <= ~rd_q;
      cnt_q <= cnt_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_q] <= din_i;
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: issues word fetches, buffers responses, inserts
// bubbles during pending branches and redirects on taken ones.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSN = NOP_INSN_DEF
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        pc_nop_control,
  input  logic        branch_resolve,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] instruction,
  output logic [31:0] id_pc
);

  fstate_e     state_q, state_d;
  logic [31:0] fpc_q, fpc_d;
  logic [31:0] tgt_q, tgt_d;
  logic [31:0] insn_q, insn_d;
  logic [31:0] idpc_q, idpc_d;
  logic [1:0]  out_q, out_d;
  logic [1:0]  drop_q, drop_d;
  logic        pend_q;

  logic        grant;
  logic        resp;
  logic        drop_dec;
  logic        push;
  logic        pop;
  logic        taken;
  logic [2:0]  credit;
  logic [31:0] tgt_al;
  logic [1:0]  cnt;
  fentry_t     head;
  fentry_t     din;

  assign resp     = imem_rvalid && (out_q != 2'd0);
  assign drop_dec = resp && (drop_q != 2'd0);
  assign push     = resp && (drop_q == 2'd0);
  assign pop      = (state_q == RUN) && !pc_nop_control
                    && (cnt != 2'd0);
  assign taken    = (state_q == BR_WAIT) && branch_resolve
                    && branch_taken;
  assign tgt_al   = branch_target & 32'hFFFF_FFFC;

  // Credit counts the slot freed by this cycle's pop so a
  // zero-wait memory sustains one instruction per cycle.
  assign credit   = {1'b0, out_q} + {1'b0, cnt} - {2'b0, pop};
  assign imem_req = !rst && (pend_q ||
                    ((state_q == RUN) && (credit < 3'd2)));
  assign imem_addr = fpc_q;
  assign grant    = imem_req && imem_gnt;

  // Live responses are contiguous and end just below fpc_q.
  assign din.pc   = fpc_q - {28'd0, out_q, 2'b00};
  assign din.insn = imem_rdata;

  fetch_buffer u_buf (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (taken),
    .din_i   (din),
    .head_o  (head),
    .count_o (cnt)
  );

  // Next-state, fetch pointer, drop accounting and decode output.
  always_comb begin
    state_d = state_q;
    fpc_d   = fpc_q;
    tgt_d   = tgt_q;
    insn_d  = NOP_INSN;
    idpc_d  = idpc_q;
    out_d   = out_q + {1'b0, grant} - {1'b0, resp};
    drop_d  = drop_q - {1'b0, drop_dec};
    if (grant) fpc_d = fpc_q + 32'd4;
    unique case (state_q)
      RUN: begin
        if (pc_nop_control) begin
          state_d = BR_WAIT;
        end else if (pop) begin
          insn_d = head.insn;
          idpc_d = head.pc;
        end
      end
      BR_WAIT: begin
        if (branch_resolve && !branch_taken) begin
          state_d = RUN;
        end else if (taken) begin
          drop_d = out_d;
          if (imem_req && !imem_gnt) begin
            tgt_d   = tgt_al;
            state_d = REDIRECT;
          end else begin
            fpc_d   = tgt_al;
            state_d = RUN;
          end
        end
      end
      REDIRECT: begin
        if (grant) begin
          drop_d  = drop_d + 2'd1;
          fpc_d   = tgt_q;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      fpc_q   <= RESET_PC;
      tgt_q   <= RESET_PC;
      insn_q  <= NOP_INSN;
      idpc_q  <= RESET_PC;
      out_q   <= 2'd0;
      drop_q  <= 2'd0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      tgt_q   <= tgt_d;
      insn_q  <= insn_d;
      idpc_q  <= idpc_d;
      out_q   <= out_d;
      drop_q  <= drop_d;
      pend_q  <= imem_req && !imem_gnt;
    end
  end

  assign instruction = insn_q;
  assign id_pc       = idpc_q;

endmodule
